// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one main-memory bus between the instruction-fetch
// port and the data port. One access in flight at a time; simultaneous requests
// are served round-robin. A watchdog aborts accesses whose response never comes.
module core_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  // Instruction-fetch port (read only)
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_ack_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  output logic                  instr_err_o,
  // Data port
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_ack_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o,
  // Main-memory bus
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_response_i
);

  // The counter holds the number of BUSY cycles already spent without a
  // response, so it only ever needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast =
      (TIMEOUT_CYCLES > 0) ? CntW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit WdogOn = (TIMEOUT_CYCLES != 0);

  localparam logic OwnInstr = 1'b0;
  localparam logic OwnData  = 1'b1;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  iack_q, iack_d;
  logic                  dack_q, dack_d;
  logic                  ierr_q, ierr_d;
  logic                  derr_q, derr_d;
  logic [DATA_WIDTH-1:0] irdata_q, irdata_d;
  logic [DATA_WIDTH-1:0] drdata_q, drdata_d;

  logic grant_any;
  logic grant_data;
  logic timeout;

  // Arbitration and watchdog decode shared by the next-state and output logic.
  always_comb begin
    grant_any  = instr_req_i | data_req_i;
    // Data wins alone, or on a tie when instr was the port served last.
    grant_data = data_req_i & (~instr_req_i | (last_q == OwnInstr));
    // A response in the same cycle takes priority over the watchdog.
    timeout    = WdogOn && (state_q == StBusy) && !mem_response_i && (cnt_q == CntLast);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_any) state_d = StBusy;
      StBusy:  if (mem_response_i || timeout) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered bus, handshake and datapath outputs.
  always_comb begin
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    iack_d   = 1'b0;
    dack_d   = 1'b0;
    ierr_d   = 1'b0;
    derr_d   = 1'b0;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          owner_d = grant_data ? OwnData : OwnInstr;
          addr_d  = grant_data ? data_addr_i : instr_addr_i;
          if (grant_data) wdata_d = data_wdata_i;
          rd_d    = ~(grant_data & data_we_i);
          wr_d    = grant_data & data_we_i;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        if (mem_response_i) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (owner_q == OwnData) begin
            dack_d = 1'b1;
            if (rd_q) drdata_d = mem_rdata_i;
          end else begin
            iack_d = 1'b1;
            if (rd_q) irdata_d = mem_rdata_i;
          end
        end else if (timeout) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (owner_q == OwnData) begin
            dack_d   = 1'b1;
            derr_d   = 1'b1;
            drdata_d = '0;
          end else begin
            iack_d   = 1'b1;
            ierr_d   = 1'b1;
            irdata_d = '0;
          end
        end else if (WdogOn) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        last_d = owner_q;
      end
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q  <= OwnInstr;
      last_q   <= OwnData;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      iack_q   <= 1'b0;
      dack_q   <= 1'b0;
      ierr_q   <= 1'b0;
      derr_q   <= 1'b0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      iack_q   <= iack_d;
      dack_q   <= dack_d;
      ierr_q   <= ierr_d;
      derr_q   <= derr_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

  assign instr_ack_o   = iack_q;
  assign instr_err_o   = ierr_q;
  assign instr_rdata_o = irdata_q;
  assign data_ack_o    = dack_q;
  assign data_err_o    = derr_q;
  assign data_rdata_o  = drdata_q;
  assign mem_read_o    = rd_q;
  assign mem_write_o   = wr_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Shares one memory bus between the core's instruction-fetch port and its data port. It sits between the core's two memory interfaces and the Controller's main-memory bus, so that a core with a single memory port can run on a board-level memory. Requests are accepted one at a time through a per-port req/ack handshake, with round-robin arbitration on simultaneous requests and a response-timeout watchdog.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- TIMEOUT_CYCLES, 1024, number of BUSY cycles without a response before an access is aborted; 0 disables the watchdog

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- instr_req_i  in  1  fetch request; held with a stable address until ack
- instr_addr_i  in  ADDR_WIDTH  fetch address
- instr_ack_o  out  1  one-cycle completion pulse
- instr_rdata_o  out  DATA_WIDTH  fetched word; valid while instr_ack_o is high
- instr_err_o  out  1  pulses with ack when the access timed out
- data_req_i  in  1  data request; held with stable address, we and wdata until ack
- data_we_i  in  1  1 = write, 0 = read
- data_addr_i  in  ADDR_WIDTH  data address
- data_wdata_i  in  DATA_WIDTH  write data
- data_ack_o  out  1  one-cycle completion pulse
- data_rdata_o  out  DATA_WIDTH  read word; valid while data_ack_o is high
- data_err_o  out  1  pulses with ack on timeout
- mem_read_o  out  1  read strobe to memory; held until response
- mem_write_o  out  1  write strobe to memory; held until response
- mem_addr_o  out  ADDR_WIDTH  registered address
- mem_wdata_o  out  DATA_WIDTH  registered write data
- mem_rdata_i  in  DATA_WIDTH  read data; valid in the mem_response_i cycle
- mem_response_i  in  1  one-cycle completion from memory

## Operation
- States: IDLE, BUSY, RESP.
- **IDLE**
  - No request pending: stay in IDLE.
  - One request pending: grant it.
  - Both pending: grant the port that was not served last. The last-served flag resets to DATA, so the first tie goes to INSTR.
  - On grant: latch addr, wdata, we and the owner; set mem_read_o or mem_write_o (instr is always a read); go to BUSY.
- **BUSY**
  - Strobe and address are held constant.
  - On mem_response_i: latch mem_rdata_i (reads only; writes leave rdata unchanged), drop the strobe, go to RESP.
  - Watchdog: a counter clears on entry to BUSY and increments each BUSY cycle without a response. When it reaches TIMEOUT_CYCLES, drop the strobe, set err, force rdata to 0, go to RESP.
  - Response and timeout in the same cycle: the response wins and err is not set.
- **RESP**
  - The owner's ack_o is high for exactly one cycle, with err_o as determined in BUSY. The other port's ack/err stay 0.
  - No grant is made in RESP.
  - Update last-served to the owner; go to IDLE.
- mem_response_i in IDLE or RESP (for example, a late response after a timeout) is ignored.
- The requester must drop or change its req at the edge after seeing ack. IDLE then samples the new intent, so no access is issued twice.
- **Reset:** at any point, including mid-BUSY, on the reset edge:
  - state = IDLE, last-served = DATA, counter = 0
  - all acks, errs and strobes = 0
  - mem_addr_o, mem_wdata_o and both rdata outputs = 0
  - the aborted access is not acknowledged.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Cycle 0: req is high in IDLE.
- Cycle 1: mem strobe is high (BUSY).
- The response arrives in cycle k ≥ 1.
- Cycle k+1: ack is high (RESP).
- Cycle k+2: IDLE, which can grant in that same cycle.
- Minimum access latency is req to ack = 2 cycles. Back-to-back throughput is one access per 3 cycles.
- Timeout: with no response, the strobe is high in cycles 1..TIMEOUT_CYCLES, and ack + err are high in cycle TIMEOUT_CYCLES+1.
- A strobe is never high in two consecutive accesses without at least one low cycle (RESP) between them.

## Test plan
- **Single instr read:** instr_req_i=1, addr=0x100; memory responds 2 cycles after strobe with 0x00000013.
  - mem_read_o high cycles 1–3, mem_addr_o=0x100.
  - instr_ack_o high in cycle 4 only, instr_rdata_o=0x00000013, instr_err_o=0.
- **Data write:** data_req_i=1, we=1, addr=0x2000, wdata=0xCAFEBABE; response on the first strobe cycle.
  - mem_write_o=1 only in cycle 1, mem_wdata_o=0xCAFEBABE.
  - data_ack_o in cycle 2, data_rdata_o unchanged.
- **Contention:** both reqs held continuously after reset, each acked port re-requesting.
  - Grants alternate INSTR, DATA, INSTR, DATA.
  - One ack every 3 cycles with an immediate-response memory.
- **Timeout:** TIMEOUT_CYCLES=8, data read, memory never responds.
  - Strobe high cycles 1–8.
  - data_ack_o=data_err_o=1 in cycle 9, data_rdata_o=0.
  - A response pulse in cycle 10 is ignored: no extra ack, no state change.
- **Reset mid-access:** reset asserted in the third BUSY cycle of an instr read.
  - Next cycle: all strobes, acks and errs are 0, state IDLE.
  - After reset drops, a pending data_req is granted first only if instr is idle; if both are pending, instr wins.
- **Response/timeout coincidence:** TIMEOUT_CYCLES=4, response arrives in the 4th BUSY cycle with data 0x55AA55AA.
  - ack with err=0 and rdata=0x55AA55AA.
